// File: rtl/bytecode_pkg.sv
// Shared definitions for the bytecode interface: opcodes, emitter states and
// the opcode-to-length rule used by the emitter, the interpreter and the bench.
package bytecode_pkg;

    localparam logic [7:0] OP_ALU2  = 8'h02;
    localparam logic [7:0] OP_ALU1  = 8'h01;
    localparam logic [7:0] OP_STI   = 8'hC2;
    localparam logic [7:0] OP_MOV   = 8'hE2;
    localparam logic [7:0] OP_PRINT = 8'h81;
    localparam logic [7:0] OP_CALL  = 8'hAA;
    localparam logic [7:0] OP_BRA   = 8'hDA;
    localparam logic [7:0] OP_RET   = 8'h55;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EMIT = 3'd1,
        HALT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

    // Encoded instruction length in bytes, opcode included; 0 marks an illegal opcode.
    function automatic logic [2:0] op_len(input logic [7:0] op);
        logic [2:0] len;
        case (op)
            OP_ALU2:                    len = 3'd4;
            OP_ALU1, OP_STI, OP_MOV:    len = 3'd3;
            OP_PRINT, OP_CALL, OP_BRA:  len = 3'd2;
            OP_RET, OP_HALT:            len = 3'd1;
            default:                    len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/bytecode_len_lut.sv
// Combinational opcode decoder: instruction length in bytes and a legality flag.
module bytecode_len_lut
    import bytecode_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic [2:0] len_o,
    output logic       legal_o
);

    assign len_o   = op_len(opcode_i);
    assign legal_o = (len_o != 3'd0);

endmodule

// File: rtl/bytecode_emitter.sv
// Serialises structured instructions into the flat program-memory byte stream,
// one byte per clock from address 0, and terminates the program with HALT.
module bytecode_emitter
    import bytecode_pkg::*;
#(
    parameter logic [7:0] MAX_ADDR  = 8'd254,
    parameter logic [7:0] HALT_BYTE = 8'hFF
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_opcode,
    input  logic [7:0] cmd_arg0,
    input  logic [7:0] cmd_arg1,
    input  logic [7:0] cmd_arg2,
    input  logic       cmd_last,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic [7:0] prog_len,
    output logic       done,
    output logic       error
);

    state_e          state_q,    state_d;
    logic [7:0]      prog_len_q, prog_len_d;
    logic [7:0]      addr_q,     addr_d;
    logic [7:0]      wdata_q,    wdata_d;
    logic [1:0]      idx_q,      idx_d;
    logic [2:0]      len_q,      len_d;
    logic            last_q,     last_d;
    logic [2:0][7:0] args_q;

    logic [2:0]      lut_len;
    logic            lut_legal;
    logic            hs;
    logic [8:0]      need;
    logic            fits;

    bytecode_len_lut u_len_lut (
        .opcode_i (cmd_opcode),
        .len_o    (lut_len),
        .legal_o  (lut_legal)
    );

    assign cmd_ready = (state_q == IDLE) && !clear;
    assign hs        = cmd_valid && cmd_ready;

    // The instruction must end at or before MAX_ADDR-1 so one byte remains for HALT.
    assign need = {1'b0, prog_len_q} + {6'b0, lut_len};
    assign fits = (need <= {1'b0, MAX_ADDR});

    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        len_d      = len_q;
        last_d     = last_q;

        if (clear) begin
            state_d    = IDLE;
            prog_len_d = 8'd0;
            addr_d     = 8'd0;
            wdata_d    = 8'd0;
            idx_d      = 2'd0;
            len_d      = 3'd0;
            last_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        if (!lut_legal || !fits) begin
                            state_d = ERR;
                        end else if (cmd_opcode == OP_HALT) begin
                            state_d = HALT;
                            addr_d  = prog_len_q;
                            wdata_d = HALT_BYTE;
                        end else begin
                            state_d = EMIT;
                            addr_d  = prog_len_q;
                            wdata_d = cmd_opcode;
                            idx_d   = 2'd0;
                            len_d   = lut_len;
                            last_d  = cmd_last;
                        end
                    end
                end
                EMIT: begin
                    // The byte at addr_q is written on this edge; line up the next one.
                    prog_len_d = prog_len_q + 8'd1;
                    if (({1'b0, idx_q} + 3'd1) == len_q) begin
                        if (last_q) begin
                            state_d = HALT;
                            addr_d  = prog_len_q + 8'd1;
                            wdata_d = HALT_BYTE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        addr_d  = prog_len_q + 8'd1;
                        wdata_d = args_q[idx_q];
                    end
                end
                HALT: begin
                    prog_len_d = prog_len_q + 8'd1;
                    state_d    = DONE;
                end
                DONE:    state_d = DONE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prog_len_q <= 8'd0;
            addr_q     <= 8'd0;
            wdata_q    <= 8'd0;
            idx_q      <= 2'd0;
            len_q      <= 3'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_len_q <= prog_len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            last_q     <= last_d;
        end
    end

    // Operand bytes are pure payload; they are only read after a fresh load.
    always_ff @(posedge clk) begin
        if (hs) begin
            args_q <= {cmd_arg2, cmd_arg1, cmd_arg0};
        end
    end

    assign mem_we    = (state_q == EMIT) || (state_q == HALT);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign prog_len  = prog_len_q;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);

endmodule
